srt_prenorm: RTL and testbench

SRT_PRENORM -- requirements
Module: srt_prenorm

---
 rtl/srt_prenorm.sv | 119 +++++++++++
 tb/tb_srt_prenorm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/srt_prenorm.sv
// Divisor pre-normalizer for an SRT divider: captures an operand pair and
// left-justifies the divisor into the 01xxxx format. It also reports the
// shift count, truncated bits and a zero divisor.
module srt_prenorm #(
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] N_in,
    input  logic [7:0] Dv_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] N_out,
    output logic [5:0] D_out,
    output logic [2:0] shift,
    output logic       inexact,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] nreg, dreg;
    logic [2:0] cnt;
    logic       zflag;

    logic       accept;
    logic [1:0] amt;
    logic [7:0] dreg_sh;
    logic [2:0] cnt_sh;

    assign accept = in_valid && (state == IDLE);

    // A double shift is only taken when it cannot push the leading one out.
    always_comb begin
        amt = 2'd1;
        if (STEP == 2 && dreg[7:6] == 2'b00)
            amt = 2'd2;
    end

    assign dreg_sh = (amt == 2'd2) ? {dreg[5:0], 2'b00} : {dreg[6:0], 1'b0};
    assign cnt_sh  = cnt + {1'b0, amt};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (Dv_in == 8'd0 || Dv_in[7])
                        state_nxt = HOLD;
                    else
                        state_nxt = NORM;
                end
            end
            NORM: begin
                if (dreg_sh[7])
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nreg  <= 8'd0;
            dreg  <= 8'd0;
            cnt   <= 3'd0;
            zflag <= 1'b0;
        end else if (accept) begin
            nreg  <= N_in;
            dreg  <= Dv_in;
            cnt   <= 3'd0;
            zflag <= (Dv_in == 8'd0);
        end else if (state == NORM) begin
            dreg <= dreg_sh;
            cnt  <= cnt_sh;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    // Data outputs are forced to zero except while a result is presented.
    always_comb begin
        N_out    = 8'd0;
        D_out    = 6'd0;
        shift    = 3'd0;
        inexact  = 1'b0;
        div_zero = 1'b0;
        if (state == HOLD) begin
            N_out = nreg;
            if (zflag) begin
                div_zero = 1'b1;
            end else begin
                D_out   = {1'b0, dreg[7:3]};
                shift   = cnt;
                inexact = |dreg[2:0];
            end
        end
    end

endmodule

// File: tb/tb_srt_prenorm.sv
// Checks srt_prenorm for STEP=1 and STEP=2 side by side against an
// arithmetic leading-zero model, using directed and random operand pairs.
module tb_srt_prenorm;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] N_in = 8'd0;
    logic [7:0] Dv_in = 8'd0;

    logic [1:0] in_ready, out_valid, inexact, div_zero;
    logic [7:0] N_out [2];
    logic [5:0] D_out [2];
    logic [2:0] shift [2];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    srt_prenorm #(.STEP(1)) u1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready[0]),
        .N_in(N_in), .Dv_in(Dv_in), .out_valid(out_valid[0]), .out_ready(out_ready),
        .N_out(N_out[0]), .D_out(D_out[0]), .shift(shift[0]),
        .inexact(inexact[0]), .div_zero(div_zero[0])
    );

    srt_prenorm #(.STEP(2)) u2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready[1]),
        .N_in(N_in), .Dv_in(Dv_in), .out_valid(out_valid[1]), .out_ready(out_ready),
        .N_out(N_out[1]), .D_out(D_out[1]), .shift(shift[1]),
        .inexact(inexact[1]), .div_zero(div_zero[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {out_valid, in_ready, N_out, D_out, shift, inexact, div_zero}
    function automatic logic [20:0] obs_vec(input int i);
        return {out_valid[i], in_ready[i], N_out[i], D_out[i], shift[i], inexact[i], div_zero[i]};
    endfunction

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_step%0d", tag, i + 1), {11'd0, obs_vec(i)}, {11'd0, 2'b01, 19'd0});
    endtask

    // Reference: left-justify the divisor by counting leading zeros.
    function automatic void model(input logic [7:0] d, output logic [5:0] dn,
                                  output logic [2:0] sh, output logic inx,
                                  output logic dz, output int lat1, output int lat2);
        int lz;
        logic [7:0] t;
        lz = 0;
        t  = d;
        dz = (d == 8'd0);
        if (dz) begin
            dn = 6'd0; sh = 3'd0; inx = 1'b0; lat1 = 0; lat2 = 0;
        end else begin
            while (t[7] == 1'b0) begin
                t = t * 2;
                lz++;
            end
            dn   = {1'b0, t[7:3]};
            sh   = 3'(lz);
            inx  = (t[2:0] != 3'd0);
            lat1 = lz;
            lat2 = (lz + 1) / 2;
        end
    endfunction

    // Called at a negedge with both DUTs idle; returns at a negedge, idle again.
    task automatic run_txn(input logic [7:0] n, input logic [7:0] d, input int stall);
        logic [5:0]  dn;
        logic [2:0]  sh;
        logic        inx, dz;
        int          elat [2];
        int          lat [2];
        logic [20:0] exp_vec;
        string       tag;
        model(d, dn, sh, inx, dz, elat[0], elat[1]);
        exp_vec = {1'b1, 1'b0, n, dn, sh, inx, dz};
        tag = $sformatf("d%02h", d);
        N_in = n; Dv_in = d; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        N_in = 8'($urandom); Dv_in = 8'($urandom);
        lat[0] = -1; lat[1] = -1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 2; i++)
                if (lat[i] < 0 && out_valid[i]) lat[i] = k;
            if (lat[0] >= 0 && lat[1] >= 0) break;
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_lat_step%0d", tag, i + 1), 32'(lat[i]), 32'(elat[i]));
            chk($sformatf("%s_out_step%0d", tag, i + 1), {11'd0, obs_vec(i)}, {11'd0, exp_vec});
        end
        // Stall with fresh operands offered: nothing may be captured.
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int s = 0; s < stall; s++) begin
                N_in = 8'($urandom); Dv_in = 8'($urandom);
                @(negedge clk);
                for (int i = 0; i < 2; i++)
                    chk($sformatf("%s_stall_step%0d", tag, i + 1), {11'd0, obs_vec(i)}, {11'd0, exp_vec});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle({tag, "_release"});
    endtask

    initial begin
        // Reset state while resetn held low.
        #12;
        check_idle("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_txn(8'h5A, 8'h80, 0);
        run_txn(8'h11, 8'h03, 0);
        run_txn(8'h22, 8'h01, 0);
        run_txn(8'h33, 8'h87, 0);
        run_txn(8'h44, 8'h00, 0);
        run_txn(8'hC3, 8'h2B, 10);
        run_txn(8'hFF, 8'hFF, 1);
        run_txn(8'h00, 8'h7F, 0);

        // Asynchronous reset while both instances are mid-normalization.
        N_in = 8'h99; Dv_in = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        resetn = 1'b1;
        run_txn(8'h3C, 8'h05, 0);

        for (int r = 0; r < 40; r++)
            run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        for (int r = 0; r < 8; r++)
            run_txn(8'($urandom), 8'($urandom_range(0, 7)), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
